// File: rtl/vga_timing_pkg.sv
// 800x600@60 VGA timing constants shared by the timing generator and the sync decoder,
// plus the decoder lock-state encoding.
package vga_timing_pkg;

  localparam int VGA_H_VISIBLE    = 800;
  localparam int VGA_H_FRONT      = 40;
  localparam int VGA_H_SYNC_WIDTH = 128;
  localparam int VGA_H_BACK       = 88;
  localparam int VGA_H_SYNC_START = VGA_H_VISIBLE + VGA_H_FRONT;
  localparam int VGA_H_TOTAL      = VGA_H_SYNC_START + VGA_H_SYNC_WIDTH + VGA_H_BACK;

  localparam int VGA_V_VISIBLE    = 600;
  localparam int VGA_V_FRONT      = 1;
  localparam int VGA_V_SYNC_WIDTH = 4;
  localparam int VGA_V_BACK       = 23;
  localparam int VGA_V_SYNC_START = VGA_V_VISIBLE + VGA_V_FRONT;
  localparam int VGA_V_TOTAL      = VGA_V_SYNC_START + VGA_V_SYNC_WIDTH + VGA_V_BACK;

  typedef enum logic [1:0] {
    SEARCH = 2'd0,
    H_LOCK = 2'd1,
    LOCKED = 2'd2
  } dec_state_e;

endpackage

// File: rtl/sync_edge_detect.sv
// Two-flop synchronizer for an asynchronous sync pin, with rise/fall detection
// against a history register that only advances on the pixel enable.
module sync_edge_detect (
  input  logic clk,
  input  logic rst,
  input  logic en_i,
  input  logic async_i,
  output logic level_o,
  output logic rise_o,
  output logic fall_o
);

  logic meta_q;
  logic sync_q;
  logic prev_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      meta_q <= 1'b0;
      sync_q <= 1'b0;
    end else begin
      meta_q <= async_i;
      sync_q <= meta_q;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      prev_q <= 1'b0;
    end else if (en_i) begin
      prev_q <= sync_q;
    end
  end

  assign level_o = sync_q;
  assign rise_o  = en_i & sync_q & ~prev_q;
  assign fall_o  = en_i & ~sync_q & prev_q;

endmodule

// File: rtl/vga_sync_decoder.sv
// Recovers x/y from a positive-polarity hsync/vsync pair with a flywheel counter,
// measures line/frame geometry and tracks lock (SEARCH -> H_LOCK -> LOCKED).
module vga_sync_decoder
  import vga_timing_pkg::*;
#(
  parameter int H_VISIBLE    = VGA_H_VISIBLE,
  parameter int H_SYNC_START = VGA_H_SYNC_START,
  parameter int H_SYNC_WIDTH = VGA_H_SYNC_WIDTH,
  parameter int H_TOTAL      = VGA_H_TOTAL,
  parameter int V_VISIBLE    = VGA_V_VISIBLE,
  parameter int V_SYNC_START = VGA_V_SYNC_START,
  parameter int V_TOTAL      = VGA_V_TOTAL,
  parameter int LOCK_LINES   = 4,
  parameter int CW           = 16
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          pix_tick,
  input  logic          hsync_in,
  input  logic          vsync_in,
  output logic [CW-1:0] x,
  output logic [CW-1:0] y,
  output logic          visible,
  output logic          locked,
  output logic [CW-1:0] h_total_meas,
  output logic [CW-1:0] h_width_meas,
  output logic [CW-1:0] v_total_meas,
  output logic          err_pulse
);

  localparam int MW = $clog2(LOCK_LINES + 1);
  localparam logic [CW-1:0] ONE_C   = CW'(1);
  localparam logic [CW-1:0] HV_C    = CW'(H_VISIBLE);
  localparam logic [CW-1:0] HSS_C   = CW'(H_SYNC_START);
  localparam logic [CW-1:0] HSW_C   = CW'(H_SYNC_WIDTH);
  localparam logic [CW-1:0] HT_C    = CW'(H_TOTAL);
  localparam logic [CW-1:0] HT_M1_C = CW'(H_TOTAL - 1);
  localparam logic [CW-1:0] HT_X2_C = CW'(2 * H_TOTAL);
  localparam logic [CW-1:0] VV_C    = CW'(V_VISIBLE);
  localparam logic [CW-1:0] VSS_C   = CW'(V_SYNC_START);
  localparam logic [CW-1:0] VT_C    = CW'(V_TOTAL);
  localparam logic [CW-1:0] VT_M1_C = CW'(V_TOTAL - 1);
  localparam logic [MW-1:0] LL_M1_C = MW'(LOCK_LINES - 1);

  function automatic logic [CW-1:0] sat_inc(input logic [CW-1:0] v);
    return (v == '1) ? v : v + ONE_C;
  endfunction

  logic hs_lvl, hs_rise, hs_fall;
  logic vs_lvl, vs_rise, vs_fall;
  logic unused_vs;

  sync_edge_detect u_hs_edge (
    .clk(clk), .rst(rst), .en_i(pix_tick), .async_i(hsync_in),
    .level_o(hs_lvl), .rise_o(hs_rise), .fall_o(hs_fall)
  );

  sync_edge_detect u_vs_edge (
    .clk(clk), .rst(rst), .en_i(pix_tick), .async_i(vsync_in),
    .level_o(vs_lvl), .rise_o(vs_rise), .fall_o(vs_fall)
  );

  assign unused_vs = vs_lvl ^ vs_fall;

  logic [CW-1:0] x_q, x_d, y_q, y_d;
  logic [CW-1:0] h_run_q, h_run_d, hw_run_q, hw_run_d;
  logic [CW-1:0] h_total_q, h_total_d, h_width_q, h_width_d;
  logic [CW-1:0] v_run_q, v_run_d, v_total_q, v_total_d;
  logic [MW-1:0] match_q, match_d;
  logic          armed_q, armed_d;
  dec_state_e    state_q, state_d;
  logic          visible_q, visible_d, locked_q, locked_d, err_q, err_d;
  logic [CW-1:0] period;
  logic          x_wrap, line_good, timeout;

  always_comb begin
    period    = sat_inc(h_run_q);
    x_wrap    = (x_q == HT_M1_C);
    h_run_d   = hs_rise ? '0 : period;
    h_total_d = hs_rise ? period : h_total_q;
    hw_run_d  = hw_run_q;
    h_width_d = h_width_q;
    if (hs_rise)     hw_run_d = ONE_C;
    else if (hs_lvl) hw_run_d = sat_inc(hw_run_q);
    if (hs_fall)     h_width_d = hw_run_q;

    if (hs_rise)     x_d = HSS_C;
    else if (x_wrap) x_d = '0;
    else             x_d = x_q + ONE_C;

    // vsync load beats the end-of-line advance
    if (vs_rise)                y_d = VSS_C;
    else if (!hs_rise && x_wrap) y_d = (y_q == VT_M1_C) ? '0 : y_q + ONE_C;
    else                        y_d = y_q;

    v_run_d   = v_run_q;
    v_total_d = v_total_q;
    if (vs_rise) begin
      v_total_d = v_run_q;
      v_run_d   = hs_rise ? ONE_C : '0;
    end else if (hs_rise) begin
      v_run_d = sat_inc(v_run_q);
    end
  end

  always_comb begin
    line_good = (period == HT_C) && (h_width_q == HSW_C);
    timeout   = !hs_rise && (h_run_d >= HT_X2_C);
    state_d   = state_q;
    match_d   = match_q;
    armed_d   = armed_q;
    err_d     = 1'b0;
    if (timeout) begin
      state_d = SEARCH;
      match_d = '0;
      err_d   = (state_q != SEARCH);
    end else begin
      case (state_q)
        SEARCH: begin
          if (hs_rise) begin
            if (!line_good) begin
              match_d = '0;
            end else if (match_q == LL_M1_C) begin
              state_d = H_LOCK;
              match_d = '0;
              armed_d = 1'b0;
            end else begin
              match_d = match_q + MW'(1);
            end
          end
        end
        H_LOCK: begin
          if (hs_rise && !line_good) begin
            state_d = SEARCH;
            err_d   = 1'b1;
          end else if (vs_rise) begin
            if (armed_q && (v_run_q == VT_C)) state_d = LOCKED;
            armed_d = 1'b1;
          end
        end
        LOCKED: begin
          if (hs_rise && !line_good) begin
            state_d = SEARCH;
            err_d   = 1'b1;
          end else if (vs_rise && (v_run_q != VT_C)) begin
            state_d = H_LOCK;
            armed_d = 1'b0;
            err_d   = 1'b1;
          end
        end
        default: state_d = SEARCH;
      endcase
    end
    locked_d  = (state_d == LOCKED);
    visible_d = locked_d && (x_d < HV_C) && (y_d < VV_C);
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      x_q       <= '0;
      y_q       <= '0;
      h_run_q   <= '0;
      hw_run_q  <= '0;
      h_total_q <= '0;
      h_width_q <= '0;
      v_run_q   <= '0;
      v_total_q <= '0;
      match_q   <= '0;
      armed_q   <= 1'b0;
      state_q   <= SEARCH;
      visible_q <= 1'b0;
      locked_q  <= 1'b0;
      err_q     <= 1'b0;
    end else if (pix_tick) begin
      x_q       <= x_d;
      y_q       <= y_d;
      h_run_q   <= h_run_d;
      hw_run_q  <= hw_run_d;
      h_total_q <= h_total_d;
      h_width_q <= h_width_d;
      v_run_q   <= v_run_d;
      v_total_q <= v_total_d;
      match_q   <= match_d;
      armed_q   <= armed_d;
      state_q   <= state_d;
      visible_q <= visible_d;
      locked_q  <= locked_d;
      err_q     <= err_d;
    end
  end

  assign x            = x_q;
  assign y            = y_q;
  assign visible      = visible_q;
  assign locked       = locked_q;
  assign h_total_meas = h_total_q;
  assign h_width_meas = h_width_q;
  assign v_total_meas = v_total_q;
  assign err_pulse    = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Bench for vga_sync_decoder on a scaled-down raster (16x10, sync at x=10..13, y=7..8)
// driven by a behavioural timing generator with a pixel enable every 6 clk.
module tb_vga_sync_decoder;

  localparam int HV  = 8;
  localparam int HSS = 10;
  localparam int HSW = 4;
  localparam int HT  = 16;
  localparam int VV  = 6;
  localparam int VSS = 7;
  localparam int VT  = 10;
  localparam int LL  = 4;
  localparam int CW  = 16;

  logic          clk, rst, pix_tick, hsync_in, vsync_in;
  logic [CW-1:0] x, y, h_total_meas, h_width_meas, v_total_meas;
  logic          visible, locked, err_pulse;

  vga_sync_decoder #(
    .H_VISIBLE(HV), .H_SYNC_START(HSS), .H_SYNC_WIDTH(HSW), .H_TOTAL(HT),
    .V_VISIBLE(VV), .V_SYNC_START(VSS), .V_TOTAL(VT), .LOCK_LINES(LL), .CW(CW)
  ) dut (
    .clk(clk), .rst(rst), .pix_tick(pix_tick), .hsync_in(hsync_in), .vsync_in(vsync_in),
    .x(x), .y(y), .visible(visible), .locked(locked),
    .h_total_meas(h_total_meas), .h_width_meas(h_width_meas),
    .v_total_meas(v_total_meas), .err_pulse(err_pulse)
  );

  int compared = 0;
  int mismatched = 0;
  int gx = 0, gy = 0, gframe = 0;
  int df = -1, dy = -1, dx = -1;
  bit track = 0;
  int vis_frame = -1, vis_cnt = 0;
  logic [63:0] sb_q[$];

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    int div;
    div = 0;
    pix_tick = 1'b0;
    forever begin
      @(negedge clk);
      div = (div == 5) ? 0 : div + 1;
      pix_tick = (div == 0);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Generator scenario hooks: stretched line, short frame, coincident syncs, missing hsync.
  function automatic int line_len();
    return (gframe == 3 && gy == 2) ? HT + 4 : HT;
  endfunction

  function automatic int frame_len();
    return (gframe == 6) ? VT - 1 : VT;
  endfunction

  function automatic logic hs_level();
    if (gframe == 12 && (gy == 2 || gy == 3)) return 1'b0;
    return (gx >= HSS && gx < HSS + HSW);
  endfunction

  function automatic logic vs_level();
    if (gframe == 10) return (gy == VSS && gx >= HSS) || (gy == VSS + 1) || (gy == VSS + 2 && gx < HSS);
    return (gy >= VSS && gy < VSS + 2);
  endfunction

  task automatic drive_pins();
    hsync_in = hs_level();
    vsync_in = vs_level();
  endtask

  task automatic tick1();
    logic [63:0] e;
    @(posedge clk);
    while (!pix_tick) @(posedge clk);
    #1;
    if (sb_q.size() > 0) begin
      e = sb_q.pop_front();
      chk("track_xyv", 64'({x, y, visible}), e);
    end
    df = gframe; dy = gy; dx = gx;
    if (visible && df == vis_frame) vis_cnt++;
    gx++;
    if (gx == line_len()) begin
      gx = 0;
      gy++;
      if (gy == frame_len()) begin
        gy = 0;
        gframe++;
      end
    end
    drive_pins();
    if (track) sb_q.push_back(64'({CW'(gx), CW'(gy), logic'(gx < HV && gy < VV)}));
  endtask

  task automatic run_until(input int f, input int yy, input int xx);
    int n;
    n = 0;
    do begin
      tick1();
      n++;
    end while (!(df == f && dy == yy && dx == xx) && n < 2000);
    if (!(df == f && dy == yy && dx == xx)) begin
      compared++;
      mismatched++;
      $error("FAIL run_until timeout: observed frame %0d line %0d px %0d, required %0d/%0d/%0d",
             df, dy, dx, f, yy, xx);
      $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
      $finish;
    end
  endtask

  task automatic chk_all_zero(input string tag);
    chk({tag, "_x"}, 64'(x), 64'(0));
    chk({tag, "_y"}, 64'(y), 64'(0));
    chk({tag, "_visible"}, 64'(visible), 64'(0));
    chk({tag, "_locked"}, 64'(locked), 64'(0));
    chk({tag, "_h_total"}, 64'(h_total_meas), 64'(0));
    chk({tag, "_h_width"}, 64'(h_width_meas), 64'(0));
    chk({tag, "_v_total"}, 64'(v_total_meas), 64'(0));
    chk({tag, "_err"}, 64'(err_pulse), 64'(0));
  endtask

  initial begin
    rst = 1'b1;
    drive_pins();
    repeat (10) @(posedge clk);
    #1;
    chk_all_zero("reset");
    @(negedge clk);
    rst = 1'b0;

    // Loopback lock: lock at the second vsync, geometry measured, visible area tracked
    run_until(1, VSS - 1, HT - 1);
    chk("t1_locked_before", 64'(locked), 64'(0));
    chk("t1_h_total", 64'(h_total_meas), 64'(HT));
    chk("t1_h_width", 64'(h_width_meas), 64'(HSW));
    tick1();
    chk("t1_locked_at_vsync", 64'(locked), 64'(1));
    chk("t1_v_total", 64'(v_total_meas), 64'(VT));
    chk("t1_y_load", 64'(y), 64'(VSS));
    track = 1;
    vis_frame = 2;
    run_until(2, VT - 1, HT - 1);
    track = 0;
    chk("t1_visible_count", 64'(vis_cnt), 64'(HV * VV));

    // Stretched line while locked
    run_until(3, 3, HSS - 1);
    chk("t3_locked_pre", 64'(locked), 64'(1));
    chk("t3_err_pre", 64'(err_pulse), 64'(0));
    tick1();
    chk("t3_err", 64'(err_pulse), 64'(1));
    chk("t3_locked", 64'(locked), 64'(0));
    chk("t3_h_total", 64'(h_total_meas), 64'(HT + 4));
    tick1();
    chk("t3_err_one_tick", 64'(err_pulse), 64'(0));
    run_until(4, VSS, 0);
    chk("t3_locked_arm", 64'(locked), 64'(0));
    run_until(5, VSS - 1, HT - 1);
    chk("t3_locked_pre_relock", 64'(locked), 64'(0));
    tick1();
    chk("t3_relock", 64'(locked), 64'(1));

    // Short frame while locked
    run_until(7, VSS - 1, HT - 1);
    chk("t5_locked_pre", 64'(locked), 64'(1));
    tick1();
    chk("t5_locked", 64'(locked), 64'(0));
    chk("t5_err", 64'(err_pulse), 64'(1));
    chk("t5_v_total", 64'(v_total_meas), 64'(VT - 1));
    run_until(8, VSS, 0);
    chk("t5_locked_arm", 64'(locked), 64'(0));
    run_until(9, VSS, 0);
    chk("t5_relock", 64'(locked), 64'(1));
    chk("t5_v_total_ok", 64'(v_total_meas), 64'(VT));

    // hsync and vsync rising on the same tick
    run_until(10, VSS, HSS);
    chk("t6_x", 64'(x), 64'(HSS));
    chk("t6_y", 64'(y), 64'(VSS));
    chk("t6_v_run", 64'(dut.v_run_q), 64'(1));
    chk("t6_locked", 64'(locked), 64'(1));
    run_until(11, VSS, 0);
    chk("t6_next_v_total", 64'(v_total_meas), 64'(VT));
    chk("t6_still_locked", 64'(locked), 64'(1));

    // hsync missing for two lines
    run_until(12, 3, HSS - 1);
    chk("t4_locked_pre", 64'(locked), 64'(1));
    tick1();
    chk("t4_locked", 64'(locked), 64'(0));
    chk("t4_err", 64'(err_pulse), 64'(1));
    chk("t4_x_no_reload", 64'(x), 64'(HSS));
    run_until(12, 4, 0);
    chk("t4_x_wrap", 64'(x), 64'(0));
    run_until(12, 4, HSS);
    chk("t4_h_total", 64'(h_total_meas), 64'(3 * HT));
    run_until(14, VSS - 1, HT - 1);
    chk("t4_locked_pre_relock", 64'(locked), 64'(0));
    tick1();
    chk("t4_relock", 64'(locked), 64'(1));

    // Asynchronous reset mid-line while locked
    run_until(14, VSS + 1, 5);
    rst = 1'b1;
    #2;
    chk_all_zero("t2_async");
    repeat (20) @(posedge clk);
    @(negedge clk);
    rst = 1'b0;
    run_until(15, VSS, 0);
    chk("t2_locked_first_vsync", 64'(locked), 64'(0));
    run_until(16, VSS - 1, HT - 1);
    chk("t2_locked_pre", 64'(locked), 64'(0));
    tick1();
    chk("t2_relock", 64'(locked), 64'(1));
    track = 1;
    run_until(17, VSS, 0);
    track = 0;
    tick1();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
